sext_unit: RTL
==============

SEXT_UNIT -- requirements
Module: sext_unit

Interface
REQ-001: Parameter WIDTH, default 16, SHALL set the output word width; legal range 12..32.
REQ-002: Parameter DEPTH, default 2, SHALL set the number of output buffer entries; a power of two, at least 2.
REQ-003: Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004: Port reset, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005: Port in_valid, input, 1 bit, SHALL mean the upstream offers an instruction word.
REQ-006: Port in_ready, output, 1 bit, SHALL mean the block accepts the offer this cycle.
REQ-007: Port ir, input, 16 bits, SHALL carry the LC-3 instruction word.
REQ-008: Port mode, input, 3 bits, SHALL select the extension: 0 = SEXT ir[10:0], 1 = SEXT ir[8:0], 2 = SEXT ir[5:0], 3 = SEXT ir[4:0], 4 = ZEXT ir[7:0] (trapvect8), 5..7 = illegal.
REQ-009: Port out_valid, output, 1 bit, SHALL mean the head buffer entry is valid.
REQ-010: Port out_ready, input, 1 bit, SHALL mean the downstream consumes the head entry this cycle.
REQ-011: Port out, output, WIDTH bits, SHALL carry the extended value of the head entry.
REQ-012: Port out_err, output, 1 bit, SHALL flag that the head entry came from an illegal mode.
REQ-013: Port count, output, $clog2(DEPTH)+1 bits, SHALL report the current number of occupied entries.

Function
REQ-014: Accept SHALL occur on a rising edge with in_valid && in_ready; pop SHALL occur on a rising edge with out_valid && out_ready.
REQ-015: in_ready SHALL be 1 exactly when count < DEPTH, with no combinational dependence on out_ready.
REQ-016: out_valid SHALL be 1 exactly when count != 0.
REQ-017: SEXT modes SHALL replicate the field MSB into every bit from the field width up to WIDTH-1.
REQ-018: ZEXT mode SHALL place ir[7:0] in bits 7:0 and zeros in all higher bits.
REQ-019: For illegal modes, the stored value SHALL be all zeros and the stored err bit SHALL be 1; legal modes SHALL store err = 0.
REQ-020: Extension SHALL be computed from ir and mode sampled at the accept edge, then stored in the tail entry.
REQ-021: Latency: a word accepted into an empty buffer at edge N SHALL appear on out/out_err with out_valid = 1 immediately after edge N.
REQ-022: Entries SHALL leave in acceptance order (FIFO); the head and tail pointers SHALL wrap modulo DEPTH.
REQ-023: Simultaneous accept and pop SHALL leave count unchanged, advance both pointers, and lose no data.
REQ-024: When full, in_ready SHALL be 0 even if out_ready = 1; a pop that edge frees one slot for the next cycle.
REQ-025: When empty, out_ready SHALL have no effect; count SHALL never underflow or exceed DEPTH.
REQ-026: out and out_err SHALL hold their values while out_valid = 1 and out_ready = 0.

Reset
REQ-027: Asserting reset SHALL immediately clear count, both pointers, out, out_err and out_valid to 0, independent of clk.
REQ-028: On reset, in_ready SHALL read 1 and all buffered entries SHALL be discarded, including on reset mid-stream.
REQ-029: The first accept SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-030: Test 1: WIDTH=16, mode=0, ir=16'h0400 -> out=16'hFC00; ir=16'h03FF -> out=16'h03FF; out_err=0 in both cases.
REQ-031: Test 2: mode=1, ir=16'h0100 -> 16'hFF00; mode=2, ir=16'h0020 -> 16'hFFE0; mode=3, ir=16'h0010 -> 16'hFFF0; mode=4, ir=16'hF0FF -> 16'h00FF.
REQ-032: Test 3: WIDTH=24, mode=3, ir=16'h001F -> out=24'hFFFFFF; mode=6 -> out=0, out_err=1.
REQ-033: Test 4: DEPTH=2, out_ready=0, push A then B -> count=2, in_ready=0; a third offer stalls; with out_ready=1, A then B emerge in order.
REQ-034: Test 5: count=1, accept and pop on the same edge continuously for 8 edges -> count stays 1 and output order equals input order.
REQ-035: Test 6: with count=2, assert reset between clk edges -> out_valid, count and out go to 0 at once; after release, in_ready=1.

Source files
------------

// File: rtl/sext_unit.sv
// LC-3 immediate/offset extension unit: extends an instruction field per mode
// and queues the result in a small ready/valid output FIFO.
module sext_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [15:0]              ir,
  input  logic [2:0]               mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] val_q [DEPTH];
  logic [WIDTH-1:0] val_d [DEPTH];
  logic             err_q [DEPTH];
  logic             err_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             push_c;
  logic             pop_c;
  logic [WIDTH-1:0] ext_c;
  logic             ext_err_c;
  logic             ir_unused_c;

  // Upper opcode bits never feed any extension field.
  assign ir_unused_c = ^ir[15:11];

  // Field extension selected by mode; illegal modes yield zero with err set.
  always_comb begin
    ext_c     = '0;
    ext_err_c = 1'b0;
    case (mode)
      3'd0:    ext_c = {{(WIDTH-11){ir[10]}}, ir[10:0]};
      3'd1:    ext_c = {{(WIDTH-9){ir[8]}},   ir[8:0]};
      3'd2:    ext_c = {{(WIDTH-6){ir[5]}},   ir[5:0]};
      3'd3:    ext_c = {{(WIDTH-5){ir[4]}},   ir[4:0]};
      3'd4:    ext_c = {{(WIDTH-8){1'b0}},    ir[7:0]};
      default: ext_err_c = 1'b1;
    endcase
  end

  assign in_ready  = (count_q < CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_c    = in_valid && in_ready;
  assign pop_c     = out_valid && out_ready;

  // FIFO next state; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    val_d   = val_q;
    err_d   = err_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_c) begin
      val_d[tail_q] = ext_c;
      err_d[tail_q] = ext_err_c;
      tail_d        = tail_q + PW'(1);
    end
    if (pop_c) begin
      head_d = head_q + PW'(1);
    end
    count_d = count_q + CW'(push_c) - CW'(pop_c);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        val_q[i] <= '0;
        err_q[i] <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      val_q   <= val_d;
      err_q   <= err_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out     = val_q[head_q];
  assign out_err = err_q[head_q];
  assign count   = count_q;

endmodule
